// File: rtl/wb2avr_slv_wb_pkg.sv
// Shared types and constants for the Wishbone-to-AVR local-bus slave bridge.
package wb2avr_slv_wb_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TERM_ACK = 2'd0,
    TERM_ERR = 2'd1,
    TERM_RTY = 2'd2
  } term_e;

  // Lowest selected byte lane; 0 when nothing is selected.
  function automatic logic [LANE_W-1:0] first_lane(input logic [LANES-1:0] sel);
    logic [LANE_W-1:0] lane;
    lane = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (sel[LANE_W'(i)]) lane = LANE_W'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/rg_md.sv
// Load-enabled holding register for request fields latched at access start.
module rg_md #(
  parameter int unsigned P_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               nrst,
  input  logic               en_i,
  input  logic [P_WIDTH-1:0] d_i,
  output logic [P_WIDTH-1:0] q_o
);

  logic [P_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/wb_lane_seq.sv
// Finds the next selected byte lane above the current one; flags the last lane.
module wb_lane_seq
  import wb2avr_slv_wb_pkg::*;
(
  input  logic [LANES-1:0]  sel_i,
  input  logic [LANE_W-1:0] cur_lane_i,
  output logic [LANE_W-1:0] nxt_lane_c_o,
  output logic              last_c_o
);

  always_comb begin
    nxt_lane_c_o = cur_lane_i;
    last_c_o     = 1'b1;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (sel_i[LANE_W'(i)] && (i > int'(cur_lane_i))) begin
        nxt_lane_c_o = LANE_W'(i);
        last_c_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb2avr_slv_wb.sv
// Wishbone classic slave that splits each 32-bit access into byte accesses
// on the AVR local I/O bus, with a per-lane timeout.
module wb2avr_slv_wb
  import wb2avr_slv_wb_pkg::*;
#(
  parameter int unsigned P_LB_ADR_WIDTH  = 16,
  parameter logic [31:0] P_WIN_BASE      = 32'h0000_0000,
  parameter int unsigned P_WIN_SIZE_LOG2 = 16,
  parameter int unsigned P_TMO_WIDTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      nrst,
  input  logic [31:0]               adr_i,
  input  logic [31:0]               dat_i,
  output logic [31:0]               dat_o,
  input  logic                      we_i,
  input  logic [LANES-1:0]          sel_i,
  input  logic                      stb_i,
  input  logic                      cyc_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      rty_o,
  output logic [P_LB_ADR_WIDTH-1:0] lb_adr,
  output logic [7:0]                lb_wdata,
  output logic                      lb_we,
  output logic                      lb_re,
  input  logic [7:0]                lb_rdata,
  input  logic                      lb_ready,
  input  logic                      lb_busy
);

  localparam int unsigned WRD_AW = P_LB_ADR_WIDTH - 2;
  localparam logic [P_TMO_WIDTH-1:0] TMO_LAST = P_TMO_WIDTH'((1 << P_TMO_WIDTH) - 2);

  state_e                    state_q, state_d;
  term_e                     term_q, term_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [P_TMO_WIDTH-1:0]    tmo_q, tmo_d;
  logic [31:0]               dat_q, dat_d;
  logic [P_LB_ADR_WIDTH-1:0] lb_adr_q, lb_adr_d;
  logic [7:0]                lb_wdata_q, lb_wdata_d;
  logic                      lb_we_q, lb_we_d, lb_re_q, lb_re_d;
  logic                      ack_q, ack_d, err_q, err_d, rty_q, rty_d;

  logic                      latch_en;
  logic [WRD_AW-1:0]         adr_q;
  logic [31:0]               wdat_q;
  logic [LANES:0]            ctl_q;
  logic                      we_q;
  logic [LANES-1:0]          sel_q;
  logic [LANE_W-1:0]         nxt_lane, first_lane_c;
  logic                      last_lane, in_win_c, tmo_hit_c;
  logic                      unused_adr;

  assign unused_adr   = ^adr_i[1:0];
  assign in_win_c     = (adr_i[31:P_WIN_SIZE_LOG2] == P_WIN_BASE[31:P_WIN_SIZE_LOG2]);
  assign first_lane_c = first_lane(sel_i);
  assign tmo_hit_c    = !lb_ready && (tmo_q == TMO_LAST);
  assign we_q         = ctl_q[LANES];
  assign sel_q        = ctl_q[LANES-1:0];

  rg_md #(.P_WIDTH(WRD_AW)) u_adr_rg (
    .clk_i(clk_i), .nrst(nrst), .en_i(latch_en),
    .d_i(adr_i[P_LB_ADR_WIDTH-1:2]), .q_o(adr_q)
  );

  rg_md #(.P_WIDTH(32)) u_dat_rg (
    .clk_i(clk_i), .nrst(nrst), .en_i(latch_en), .d_i(dat_i), .q_o(wdat_q)
  );

  rg_md #(.P_WIDTH(LANES + 1)) u_ctl_rg (
    .clk_i(clk_i), .nrst(nrst), .en_i(latch_en), .d_i({we_i, sel_i}), .q_o(ctl_q)
  );

  wb_lane_seq u_lane_seq (
    .sel_i(sel_q), .cur_lane_i(lane_q), .nxt_lane_c_o(nxt_lane), .last_c_o(last_lane)
  );

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    lane_d     = lane_q;
    tmo_d      = tmo_q;
    dat_d      = dat_q;
    lb_adr_d   = lb_adr_q;
    lb_wdata_d = lb_wdata_q;
    lb_we_d    = lb_we_q;
    lb_re_d    = lb_re_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    latch_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          dat_d   = '0;
          state_d = ST_RESP;
          if (!in_win_c)            term_d = TERM_ERR;
          else if (lb_busy)         term_d = TERM_RTY;
          else if (sel_i == '0)     term_d = TERM_ACK;
          else begin
            latch_en   = 1'b1;
            lane_d     = first_lane_c;
            tmo_d      = '0;
            lb_adr_d   = {adr_i[P_LB_ADR_WIDTH-1:2], first_lane_c};
            lb_wdata_d = dat_i[{first_lane_c, 3'b000} +: 8];
            lb_we_d    = we_i;
            lb_re_d    = !we_i;
            state_d    = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (lb_ready || tmo_hit_c) begin
          if (lb_ready && !we_q) dat_d[{lane_q, 3'b000} +: 8] = lb_rdata;
          tmo_d = lb_ready ? '0 : tmo_q + 1'b1;
          if (!cyc_i || tmo_hit_c || last_lane) begin
            lb_we_d = 1'b0;
            lb_re_d = 1'b0;
            if (!cyc_i) begin
              state_d = ST_IDLE;
            end else begin
              ack_d   = !tmo_hit_c;
              err_d   = tmo_hit_c;
              state_d = ST_RESP;
            end
          end else begin
            lane_d     = nxt_lane;
            lb_adr_d   = {adr_q, nxt_lane};
            lb_wdata_d = wdat_q[{nxt_lane, 3'b000} +: 8];
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESP: begin
        // A pulse already raised from ACC falls here; otherwise raise the latched one.
        if (ack_q || err_q || rty_q) begin
          state_d = ST_IDLE;
        end else begin
          ack_d = (term_q == TERM_ACK);
          err_d = (term_q == TERM_ERR);
          rty_d = (term_q == TERM_RTY);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      term_q     <= TERM_ACK;
      lane_q     <= '0;
      tmo_q      <= '0;
      dat_q      <= '0;
      lb_adr_q   <= '0;
      lb_wdata_q <= '0;
      lb_we_q    <= 1'b0;
      lb_re_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
    end else begin
      term_q     <= term_d;
      lane_q     <= lane_d;
      tmo_q      <= tmo_d;
      dat_q      <= dat_d;
      lb_adr_q   <= lb_adr_d;
      lb_wdata_q <= lb_wdata_d;
      lb_we_q    <= lb_we_d;
      lb_re_q    <= lb_re_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rty_q      <= rty_d;
    end
  end

  assign dat_o    = dat_q;
  assign lb_adr   = lb_adr_q;
  assign lb_wdata = lb_wdata_q;
  assign lb_we    = lb_we_q;
  assign lb_re    = lb_re_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign rty_o    = rty_q;

endmodule
